eedc_hamming_encoder_pipe: RTL and testbench
============================================

// Module: eedc_hamming_encoder_pipe
// PURPOSE
//  Parametrised, pipelined Hamming encoder for the EEDC datapath. Successor to
//  the fixed 7->11 encoder: generic data width, valid/ready handshake on both
//  sides with full-rate backpressure, and an encoded-word counter.
//  Optional overall-parity bit turns the code into SECDED.
// PARAMETERS
//  DATA_W   7   data bits per word (range 1..57)
//  COUNT_W  16  width of enc_count
//  Derived: P = smallest int with 2**P >= DATA_W+P+1 (7->4, 8->4, 26->5).
//  Derived: CODE_W = DATA_W+P, plus 1 when EEDC_SECDED_EN is defined.
// PORTS
//  clk             in   1        rising-edge clock
//  rst_n           in   1        asynchronous, active-low reset
//  data_input      in   DATA_W   word to encode
//  in_valid        in   1        data_input valid
//  in_ready        out  1        block can accept a word this cycle
//  encoded_output  out  CODE_W   codeword
//  out_valid       out  1        encoded_output valid
//  out_ready       in   1        downstream accepts the codeword
//  enc_count       out  COUNT_W  number of codewords delivered (out handshakes)
// BEHAVIOUR
//  Reset: all pipeline state clears asynchronously. Outputs after reset:
//   out_valid=0, encoded_output=0, enc_count=0. in_ready=1 once reset releases.
//  Reset mid-operation discards all in-flight words. No output is produced
//   for those words.
//  Code layout: codeword positions 1..(DATA_W+P). Position i maps to
//   encoded_output[i-1].
//   - Parity bits sit at the power-of-two positions (1,2,4,8,...).
//   - Data bits fill the remaining positions in ascending order, LSB first.
//   - Parity at position 2**k = XOR of all data positions whose index has bit
//     k set (even parity).
//  Pipeline: two stages, S1 (input register) and S2 (codeword register).
//   - Each stage has its own valid flag.
//   - A word is accepted when in_valid & in_ready.
//   - Latency: accept at edge N gives out_valid=1 after edge N+1.
//   - Throughput: one word per cycle while out_ready=1.
//  Advance rules:
//   - S2 loads from S1 when s1_valid & (!s2_valid | out_ready).
//   - in_ready = !s1_valid | !s2_valid | out_ready. Purely combinational, so
//     no bubble is lost.
//   - Accept and S1->S2 advance may occur in the same cycle (S1 refilled).
//   - Both stages full and out_ready=0: in_ready=0 and state holds.
//  Stability: while out_valid & !out_ready, encoded_output and out_valid stay
//   unchanged.
//  enc_count: increments by 1 on each out_valid & out_ready edge.
//   Wraps 2**COUNT_W-1 -> 0 with no flag.
//  X-safety: data_input is ignored when in_valid=0. S1/S2 data registers load
//   only on advance.
// CONFIGURATION
//  EEDC_SECDED_EN defined:
//   - Adds overall parity bit at encoded_output[CODE_W-1] = XOR of all other
//     codeword bits (even).
//   - CODE_W grows by 1.
//  EEDC_SECDED_EN undefined: plain Hamming SEC code, CODE_W = DATA_W+P.
//  Latency and handshake are identical in both builds.
// TESTING
//  Run every scenario in both builds (EEDC_SECDED_EN undefined and defined).
//  1 Reset, then DATA_W=7 inputs 0000000/0000001/0000010, out_ready=1
//    -> outputs 0x000 / 11'b00000000111 / 11'b00000011001 (SECDED build:
//    12'b0, 12'b100000000111, 12'b100000011001), each 2 edges after accept.
//  2 Stream all 128 values back-to-back, out_ready=1
//    -> in_ready stays 1, one codeword per cycle, each matches reference
//    model, enc_count=128.
//  3 Hold out_ready=0 while feeding 3 words
//    -> 2 accepted, then in_ready=0, encoded_output frozen.
//    Release out_ready -> words emerge in order, none lost or duplicated.
//  4 Random in_valid/out_ready (50%) for 10k cycles, DATA_W=26 (P=5)
//    -> scoreboard match, in-order delivery, no output change while stalled.
//  5 Assert rst_n low with both stages full
//    -> out_valid=0 and enc_count=0 immediately (async). Stale words never
//    appear after release.
//  6 COUNT_W=4, deliver 17 words -> enc_count wraps 15->0, reads 1 at end.

Source files
------------

// File: rtl/eedc_hamming_encoder_pipe.sv
// Purpose : parametrised two-stage Hamming encoder (SEC, or SECDED when
//           EEDC_SECDED_EN is defined) with an encoded-word delivery counter.
// Latency : a word accepted at edge N presents out_valid=1 after edge N+1.
// Backpr. : full-rate valid/ready; in_ready drops only when both stages are
//           full and out_ready=0, and the output then holds steady.
// Ports   : clk/rst_n (async active-low) | data_input,in_valid,in_ready (upstream)
//           encoded_output,out_valid,out_ready (downstream) | enc_count (delivered words)
// Config  : `define EEDC_SECDED_EN adds an overall even-parity bit at the MSB.
module eedc_hamming_encoder_pipe #(
    parameter int DATA_W  = 7,
    parameter int COUNT_W = 16,
    // Smallest P with 2**P >= DATA_W+P+1, tabulated for the supported 1..57 range.
    localparam int P = (DATA_W <= 1)  ? 2 :
                       (DATA_W <= 4)  ? 3 :
                       (DATA_W <= 11) ? 4 :
                       (DATA_W <= 26) ? 5 :
                       (DATA_W <= 57) ? 6 : 7,
    localparam int HAM_W = DATA_W + P,
`ifdef EEDC_SECDED_EN
    localparam int CODE_W = HAM_W + 1
`else
    localparam int CODE_W = HAM_W
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  data_input,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [CODE_W-1:0]  encoded_output,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] enc_count
);

    logic               s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0]  s1_data_q;
    logic               s2_vld_q, s2_vld_d;
    logic [CODE_W-1:0]  s2_code_q;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [CODE_W-1:0]  code_c;

    logic accept;
    logic adv_s2;
    logic deliver;

    assign adv_s2  = s1_vld_q & (~s2_vld_q | out_ready);
    // Combinational ready: a full S1 can still take a word when it is
    // draining into S2 in the same cycle.
    assign in_ready = ~s1_vld_q | ~s2_vld_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign deliver  = s2_vld_q & out_ready;

    // Codeword built from S1 so S2 is a pure register stage.
    always_comb begin
        int   d;
        logic par;
        code_c = '0;
        d      = 0;
        par    = 1'b0;
        // Data bits fill the non-power-of-two positions, LSB first.
        for (int pos = 1; pos <= HAM_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                code_c[pos-1] = s1_data_q[d];
                d++;
            end
        end
        // Parity at position 2**k covers every data position with bit k set.
        for (int k = 0; k < P; k++) begin
            par = 1'b0;
            for (int pos = 1; pos <= HAM_W; pos++) begin
                if (((pos & (pos - 1)) != 0) && (((pos >> k) & 1) != 0)) begin
                    par = par ^ code_c[pos-1];
                end
            end
            code_c[(1 << k) - 1] = par;
        end
`ifdef EEDC_SECDED_EN
        code_c[CODE_W-1] = ^code_c[HAM_W-1:0];
`endif
    end

    always_comb begin
        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;
        cnt_d    = cnt_q;
        if (accept) begin
            s1_vld_d = 1'b1;
        end else if (adv_s2) begin
            s1_vld_d = 1'b0;
        end
        if (adv_s2) begin
            s2_vld_d = 1'b1;
        end else if (out_ready) begin
            s2_vld_d = 1'b0;
        end
        if (deliver) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_code_q <= '0;
            cnt_q     <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            cnt_q    <= cnt_d;
            // Data registers load only on a real transfer, so an idle X on
            // data_input never reaches the pipeline.
            if (accept) begin
                s1_data_q <= data_input;
            end
            if (adv_s2) begin
                s2_code_q <= code_c;
            end
        end
    end

    assign out_valid      = s2_vld_q;
    assign encoded_output = s2_code_q;
    assign enc_count      = cnt_q;

endmodule

// File: tb/tb_eedc_hamming_encoder_pipe.sv
module tb_eedc_hamming_encoder_pipe;

`ifdef EEDC_SECDED_EN
    localparam int SEC = 1;
`else
    localparam int SEC = 0;
`endif
    localparam int CW_A = 7 + 4 + SEC;
    localparam int CW_B = 26 + 5 + SEC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: DATA_W=7, COUNT_W=16
    logic [6:0]      din_a = '0;
    logic            in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
    logic [CW_A-1:0] code_a;
    logic [15:0]     count_a;
    // DUT B: DATA_W=26, COUNT_W=4
    logic [25:0]     din_b = '0;
    logic            in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
    logic [CW_B-1:0] code_b;
    logic [3:0]      count_b;

    eedc_hamming_encoder_pipe #(.DATA_W(7), .COUNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_input(din_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .encoded_output(code_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .enc_count(count_a));

    eedc_hamming_encoder_pipe #(.DATA_W(26), .COUNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_input(din_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .encoded_output(code_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .enc_count(count_b));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: place data in non-power-of-two slots, then pick the parity
    // bits so that the XOR of the positions of all 1 bits is zero.
    function automatic logic [63:0] ref_enc(input logic [63:0] data, input int dw);
        logic [63:0] cw;
        int p, syn, j;
        cw = '0; syn = 0; j = 0; p = 0;
        while ((1 << p) < dw + p + 1) p++;
        for (int pos = 1; j < dw; pos++) begin
            if ($countones(pos) != 1) begin
                if (data[j]) begin
                    cw[pos-1] = 1'b1;
                    syn = syn ^ pos;
                end
                j++;
            end
        end
        for (int k = 0; k < p; k++) cw[(1 << k) - 1] = syn[k];
        if (SEC != 0) cw[dw+p] = ^cw;
        return cw;
    endfunction

    // Scoreboards, sampled on the falling edge (inputs change just after rise).
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    int cnt_a = 0, cnt_b = 0;
    bit stall_a = 0, stall_b = 0;
    logic [63:0] hold_a, hold_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete(); cnt_a = 0; stall_a = 0;
        end else begin
            if (stall_a) begin
                chk("A hold valid", 64'(out_valid_a), 64'd1);
                chk("A hold code", 64'(code_a), hold_a);
            end
            chk("A count", 64'(count_a), 64'(cnt_a));
            if (out_valid_a && out_ready_a) begin
                if (qa.size() == 0) chk("A unexpected output", 64'(code_a), 64'hDEAD);
                else chk("A code", 64'(code_a), ref_enc(qa.pop_front(), 7));
                cnt_a = (cnt_a + 1) & 16'hFFFF;
            end
            if (in_valid_a && in_ready_a) qa.push_back(64'(din_a));
            stall_a = out_valid_a && !out_ready_a;
            hold_a  = 64'(code_a);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            qb.delete(); cnt_b = 0; stall_b = 0;
        end else begin
            if (stall_b) begin
                chk("B hold valid", 64'(out_valid_b), 64'd1);
                chk("B hold code", 64'(code_b), hold_b);
            end
            chk("B count", 64'(count_b), 64'(cnt_b));
            if (out_valid_b && out_ready_b) begin
                if (qb.size() == 0) chk("B unexpected output", 64'(code_b), 64'hDEAD);
                else chk("B code", 64'(code_b), ref_enc(qb.pop_front(), 26));
                cnt_b = (cnt_b + 1) & 4'hF;
            end
            if (in_valid_b && in_ready_b) qb.push_back(64'(din_b));
            stall_b = out_valid_b && !out_ready_b;
            hold_b  = 64'(code_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic [6:0]  data;
        logic [11:0] exp_sec;
        logic [11:0] exp_secded;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{7'b0000000, 12'h000, 12'h000};
        tbl[1] = '{7'b0000001, 12'h007, 12'h807};
        tbl[2] = '{7'b0000010, 12'h019, 12'h819};
        tbl[3] = '{7'b1111111, 12'h7FF, 12'hFFF};
        tbl[4] = '{7'b1000000, 12'h483, 12'h483};

        // Reset state
        tick();
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", 64'(in_ready_a), 64'd1);
        chk("reset out_valid", 64'(out_valid_a), 64'd0);
        chk("reset code", 64'(code_a), 64'd0);
        chk("reset count", 64'(count_a), 64'd0);
        chk("reset B out_valid", 64'(out_valid_b), 64'd0);

        // 1: known vectors, latency check
        for (int i = 0; i < 5; i++) begin
            din_a = tbl[i].data; in_valid_a = 1'b1; out_ready_a = 1'b1;
            tick();
            chk("vec out_valid after accept edge", 64'(out_valid_a), 64'd0);
            in_valid_a = 1'b0;
            tick();
            chk("vec out_valid next edge", 64'(out_valid_a), 64'd1);
            chk("vec code", 64'(code_a), 64'((SEC != 0) ? tbl[i].exp_secded : tbl[i].exp_sec));
            tick();
        end

        // 2: stream all 128 values
        pulse_reset();
        for (int v = 0; v < 128; v++) begin
            din_a = 7'(v); in_valid_a = 1'b1;
            chk("stream in_ready", 64'(in_ready_a), 64'd1);
            if (v >= 2) chk("stream out_valid", 64'(out_valid_a), 64'd1);
            tick();
        end
        in_valid_a = 1'b0;
        repeat (3) tick();
        chk("stream count", 64'(count_a), 64'd128);
        chk("stream drained", 64'(qa.size()), 64'd0);

        // 3: stall with three words offered
        out_ready_a = 1'b0;
        din_a = 7'h11; in_valid_a = 1'b1;
        chk("stall rdy0", 64'(in_ready_a), 64'd1);
        tick();
        din_a = 7'h22;
        chk("stall rdy1", 64'(in_ready_a), 64'd1);
        tick();
        din_a = 7'h33;
        for (int i = 0; i < 4; i++) begin
            chk("stall in_ready low", 64'(in_ready_a), 64'd0);
            chk("stall frozen code", 64'(code_a), ref_enc(64'h11, 7));
            tick();
        end
        out_ready_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        repeat (4) tick();
        chk("stall drained", 64'(qa.size()), 64'd0);
        chk("stall count", 64'(count_a), 64'd131);

        // 6: counter wrap on B (COUNT_W=4)
        out_ready_b = 1'b1;
        for (int i = 0; i < 17; i++) begin
            din_b = 26'($urandom); in_valid_b = 1'b1;
            tick();
        end
        in_valid_b = 1'b0;
        repeat (3) tick();
        chk("wrap count", 64'(count_b), 64'd1);

        // 4: random handshakes on both DUTs
        for (int c = 0; c < 10000; c++) begin
            in_valid_a  = 1'($urandom); out_ready_a = 1'($urandom);
            din_a       = 7'($urandom);
            in_valid_b  = 1'($urandom); out_ready_b = 1'($urandom);
            din_b       = 26'($urandom);
            tick();
        end
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        out_ready_a = 1'b1; out_ready_b = 1'b1;
        repeat (4) tick();
        chk("random A drained", 64'(qa.size()), 64'd0);
        chk("random B drained", 64'(qb.size()), 64'd0);

        // 5: async reset with both stages full
        out_ready_a = 1'b0; out_ready_b = 1'b0;
        in_valid_a = 1'b1; in_valid_b = 1'b1;
        din_a = 7'h55; din_b = 26'h155_5555;
        repeat (3) tick();
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        chk("full A in_ready", 64'(in_ready_a), 64'd0);
        chk("full A out_valid", 64'(out_valid_a), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async A out_valid", 64'(out_valid_a), 64'd0);
        chk("async A count", 64'(count_a), 64'd0);
        chk("async A code", 64'(code_a), 64'd0);
        chk("async B out_valid", 64'(out_valid_b), 64'd0);
        chk("async B count", 64'(count_b), 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready_a = 1'b1; out_ready_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post-reset A no output", 64'(out_valid_a), 64'd0);
            chk("post-reset B no output", 64'(out_valid_b), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
